// File: rtl/reg_dump_unit.sv
// Debug register dumper: borrows the bank's rs1 read port, walks registers 0..NUM_REGS-1
// and streams {addr,data} over valid/ready, keeping a running XOR checksum of accepted words.
module reg_dump_unit #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_req,
    input  logic              abort,
    input  logic              cpu_idle,
    output logic              stall_cpu,
    output logic [ADDR_W-1:0] rb_rs1_addr,
    input  logic [DATA_W-1:0] rb_rs1_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_IDLE = 3'd1,
        S_ADDR      = 3'd2,
        S_SEND      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   rb_addr_q, rb_addr_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic                stall_q, stall_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;
    logic                last_word;

    // State and all registered outputs share one asynchronous, active-high reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rb_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            checksum_q  <= '0;
            stall_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rb_addr_q   <= rb_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            checksum_q  <= checksum_d;
            stall_q     <= stall_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign accept    = (state_q == S_SEND) && out_valid_q && out_ready && !abort;
    assign last_word = (idx_q == LAST_IDX);

    // Abort overrides everything, including a fresh request seen in IDLE.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (dump_req) state_d = S_WAIT_IDLE;
                S_WAIT_IDLE: if (cpu_idle) state_d = S_ADDR;
                S_ADDR:      state_d = S_SEND;
                S_SEND:      if (accept) state_d = last_word ? S_DONE : S_ADDR;
                S_DONE:      state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        idx_d       = idx_q;
        rb_addr_d   = rb_addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        checksum_d  = checksum_q;
        out_valid_d = (state_d == S_SEND);
        stall_d     = (state_d != S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);

        if (state_q == S_IDLE && state_d == S_WAIT_IDLE) begin
            idx_d      = '0;
            rb_addr_d  = '0;
            checksum_d = '0;
        end

        if (state_q == S_WAIT_IDLE && state_d == S_ADDR) begin
            rb_addr_d = idx_q;
        end

        // The bank captured registers[idx] on the negedge inside ADDR; latch it now.
        if (state_q == S_ADDR && state_d == S_SEND) begin
            out_data_d = rb_rs1_data;
            out_addr_d = idx_q;
        end

        if (accept) begin
            checksum_d = checksum_q ^ out_data_q;
            if (!last_word) begin
                idx_d     = idx_q + ADDR_W'(1);
                rb_addr_d = idx_q + ADDR_W'(1);
            end
        end
    end

    assign stall_cpu   = stall_q;
    assign rb_rs1_addr = rb_addr_q;
    assign out_valid   = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign checksum    = checksum_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit: models the register bank (negedge read) and predicts each dumped
// word and the XOR checksum directly from the bank contents.
module tb_reg_dump_unit;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dump_req;
    logic              abort;
    logic              cpu_idle;
    logic              stall_cpu;
    logic [ADDR_W-1:0] rb_rs1_addr;
    logic [DATA_W-1:0] rb_rs1_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    logic [DATA_W-1:0] bank_regs [NUM_REGS];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    reg_dump_unit #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_req   (dump_req),
        .abort      (abort),
        .cpu_idle   (cpu_idle),
        .stall_cpu  (stall_cpu),
        .rb_rs1_addr(rb_rs1_addr),
        .rb_rs1_data(rb_rs1_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Bank read port registers its output on the falling edge.
    always @(negedge clk) rb_rs1_data <= bank_regs[rb_rs1_addr];

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] bankXor(input int lo, input int hi);
        logic [DATA_W-1:0] acc = '0;
        for (int i = lo; i <= hi; i++) acc ^= bank_regs[i];
        return acc;
    endfunction

    task automatic checkIdle(input string tag, input logic [DATA_W-1:0] exp_sum);
        checkOutput({tag, " stall"}, 32'(stall_cpu), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " checksum"}, checksum, exp_sum);
    endtask

    task automatic checkReset(input string tag);
        checkIdle(tag, 32'd0);
        checkOutput({tag, " rs1_addr"}, 32'(rb_rs1_addr), 32'd0);
        checkOutput({tag, " out_addr"}, 32'(out_addr), 32'd0);
        checkOutput({tag, " out_data"}, out_data, 32'd0);
    endtask

    // One dump request followed by cycle-by-cycle prediction of every accepted word.
    task automatic runDump(input string name, input int idle_wait, input int bp_addr,
                           input int abort_addr, input int reset_addr,
                           input bit rand_ready, input bit rand_req,
                           output logic [DATA_W-1:0] final_sum, output int edges);
        int                exp_idx  = 0;
        logic [DATA_W-1:0] exp_sum  = '0;
        int                bp_left  = 5;
        bit                finished = 0;
        bit                pre_valid, pre_ready, pre_idle;
        logic [ADDR_W-1:0] pre_addr;
        logic [DATA_W-1:0] pre_data;

        dump_req  = 1'b1;
        abort     = 1'b0;
        out_ready = 1'b1;
        cpu_idle  = (idle_wait == 0);
        applyStimulus();
        edges    = 1;
        dump_req = 1'b0;
        checkOutput({name, " stall after req"}, 32'(stall_cpu), 32'd1);
        checkOutput({name, " busy after req"}, 32'(busy), 32'd1);
        checkOutput({name, " checksum cleared"}, checksum, 32'd0);

        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            cpu_idle  = (cyc >= idle_wait);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bp_addr >= 0 && out_valid && int'(out_addr) == bp_addr && bp_left > 0) begin
                out_ready = 1'b0;
                bp_left--;
            end
            dump_req = rand_req ? 1'($urandom_range(0, 1)) : 1'b0;
            abort    = (abort_addr >= 0 && out_valid && int'(out_addr) == abort_addr);
            if (abort) out_ready = 1'b1;

            if (reset_addr >= 0 && out_valid && int'(out_addr) == reset_addr) begin
                dump_req = 1'b0;
                rst_n    = 1'b1;
                #1;
                checkReset({name, " mid-dump reset"});
                exp_sum  = '0;
                finished = 1;
            end else begin
                pre_valid = out_valid;
                pre_ready = out_ready;
                pre_idle  = cpu_idle;
                pre_addr  = out_addr;
                pre_data  = out_data;
                applyStimulus();
                edges++;

                if (abort) begin
                    abort = 1'b0;
                    checkIdle({name, " after abort"}, exp_sum);
                    applyStimulus();
                    checkIdle({name, " abort settle"}, exp_sum);
                    finished = 1;
                end else begin
                    if (!pre_idle) begin
                        checkOutput({name, " wait valid"}, 32'(out_valid), 32'd0);
                        checkOutput({name, " wait stall"}, 32'(stall_cpu), 32'd1);
                    end
                    if (pre_valid && pre_ready) begin
                        checkOutput({name, " word addr"}, 32'(pre_addr), 32'(exp_idx));
                        checkOutput({name, " word data"}, pre_data, bank_regs[exp_idx % NUM_REGS]);
                        exp_sum ^= bank_regs[exp_idx % NUM_REGS];
                        exp_idx++;
                        checkOutput({name, " bubble"}, 32'(out_valid), 32'd0);
                    end else if (pre_valid) begin
                        checkOutput({name, " hold valid"}, 32'(out_valid), 32'd1);
                        checkOutput({name, " hold addr"}, 32'(out_addr), 32'(pre_addr));
                        checkOutput({name, " hold data"}, out_data, pre_data);
                    end
                    if (done) begin
                        dump_req = 1'b0;
                        checkOutput({name, " word count"}, 32'(exp_idx), 32'(NUM_REGS));
                        checkOutput({name, " checksum at done"}, checksum, exp_sum);
                        checkOutput({name, " stall in done"}, 32'(stall_cpu), 32'd1);
                        applyStimulus();
                        checkIdle({name, " after done"}, exp_sum);
                        finished = 1;
                    end
                end
            end
        end
        checkOutput({name, " finished in budget"}, 32'(finished), 32'd1);
        dump_req  = 1'b0;
        abort     = 1'b0;
        final_sum = exp_sum;
    endtask

    initial begin
        logic [DATA_W-1:0] sum;
        int                edges;

        for (int i = 0; i < NUM_REGS; i++) bank_regs[i] = '0;
        bank_regs[14] = 32'd1023;

        rst_n     = 1'b1;
        dump_req  = 1'b0;
        abort     = 1'b0;
        cpu_idle  = 1'b0;
        out_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        checkReset("reset");
        rst_n = 1'b0;
        applyStimulus();
        checkIdle("post reset", 32'd0);

        runDump("t1", 0, -1, -1, -1, 1'b0, 1'b0, sum, edges);
        checkOutput("t1 edges to done", 32'(edges), 32'd34);
        checkOutput("t1 checksum", checksum, 32'h0000_03FF);
        repeat (3) applyStimulus();
        checkOutput("t1 checksum hold", checksum, 32'h0000_03FF);

        bank_regs[1] = 32'hA5A5_A5A5;
        bank_regs[2] = 32'h0F0F_0F0F;
        runDump("t2", 0, -1, -1, -1, 1'b1, 1'b0, sum, edges);
        checkOutput("t2 checksum", checksum, 32'hA5A5_A5A5 ^ 32'h0F0F_0F0F ^ 32'h0000_03FF);

        runDump("t3", 0, 3, -1, -1, 1'b0, 1'b0, sum, edges);
        checkOutput("t3 checksum", checksum, bankXor(0, NUM_REGS - 1));

        runDump("t4", 10, -1, -1, -1, 1'b0, 1'b0, sum, edges);
        checkOutput("t4 edges to done", 32'(edges), 32'd44);

        dump_req = 1'b1;
        abort    = 1'b1;
        applyStimulus();
        dump_req = 1'b0;
        abort    = 1'b0;
        checkIdle("req+abort in idle", bankXor(0, NUM_REGS - 1));

        for (int i = 0; i < NUM_REGS; i++) bank_regs[i] = $urandom;
        runDump("t5", 2, -1, 7, -1, 1'b1, 1'b0, sum, edges);
        checkOutput("t5 partial checksum", checksum, bankXor(0, 6));
        repeat (3) applyStimulus();
        checkIdle("t5 idle hold", bankXor(0, 6));

        runDump("t6", 1, -1, -1, 9, 1'b1, 1'b1, sum, edges);
        applyStimulus();
        checkReset("t6 held in reset");
        rst_n = 1'b0;
        applyStimulus();
        checkIdle("t6 after release", 32'd0);

        for (int i = 0; i < NUM_REGS; i++) bank_regs[i] = $urandom;
        runDump("t7", int'($urandom_range(0, 4)), -1, -1, -1, 1'b1, 1'b1, sum, edges);
        checkOutput("t7 checksum", checksum, bankXor(0, NUM_REGS - 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
